// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the shared-ALU arbiter/sequencer.
//               - alu_op_e : 2-bit ALU function code (op[1:0] of a request)
//               - state_e  : sequencer state (IDLE / EXEC / RESP)
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin picker, purely combinational.
//               On a tie the requester that did not win last time is chosen;
//               a lone requester always wins.
// Ports       : req[1:0]   in  request vector
//               last_grant in  id of the previous winner
//               enable     in  arbitration allowed this cycle
//               gnt[1:0]   out one-hot grant (all zero when disabled/idle)
//               gnt_id     out index of the granted requester
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (enable) begin
            case (req)
                2'b01: begin
                    gnt    = 2'b01;
                    gnt_id = 1'b0;
                end
                2'b10: begin
                    gnt    = 2'b10;
                    gnt_id = 1'b1;
                end
                2'b11: begin
                    gnt_id = ~last_grant;
                    gnt    = last_grant ? 2'b01 : 2'b10;
                end
                default: begin
                    gnt    = 2'b00;
                    gnt_id = 1'b0;
                end
            endcase
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin arbiter and sequencer for one shared integer ALU
//               serving two requesters. One operation in flight at a time:
//               IDLE (arbitrate/capture) -> EXEC (compute) -> RESP (handshake).
// Ports       : clk, rst                 clock, async active-high reset
//               reqN_valid/ready         request handshake, requester N
//               reqN_a, reqN_b, reqN_op  operands and op (op[2] ignored)
//               rspN_valid/ready         response handshake, requester N
//               rsp_result, rsp_zero     shared registered result and zero flag
// Revision    : 1.0  initial release
// ============================================================================
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    state_e           r_state;
    logic             r_last_grant;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    alu_op_e          r_op;

    logic [1:0]       w_gnt;
    logic             w_gnt_id;
    logic             w_enable;
    logic             w_rsp_ready_sel;
    logic             w_unused;

    // Ready must stay low while reset is held, even though state is IDLE.
    assign w_enable = (r_state == ST_IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (r_last_grant),
        .enable     (w_enable),
        .gnt        (w_gnt),
        .gnt_id     (w_gnt_id)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    assign rsp0_valid = (r_state == ST_RESP) && !r_id;
    assign rsp1_valid = (r_state == ST_RESP) &&  r_id;

    // Only the owner's ready can retire the response.
    assign w_rsp_ready_sel = r_id ? rsp1_ready : rsp0_ready;

    assign w_unused = req0_op[2] ^ req1_op[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= ALU_ADD;
            rsp_result   <= '0;
            rsp_zero     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_a          <= w_gnt_id ? req1_a : req0_a;
                        r_b          <= w_gnt_id ? req1_b : req0_b;
                        r_op         <= alu_op_e'(w_gnt_id ? req1_op[1:0] : req0_op[1:0]);
                        r_id         <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_op)
                        ALU_ADD: begin
                            rsp_result <= r_a + r_b;
                            rsp_zero   <= ((r_a + r_b) == '0);
                        end
                        ALU_SUB: begin
                            rsp_result <= r_a - r_b;
                            rsp_zero   <= ((r_a - r_b) == '0);
                        end
                        ALU_AND: begin
                            rsp_result <= r_a & r_b;
                            rsp_zero   <= ((r_a & r_b) == '0);
                        end
                        default: begin
                            rsp_result <= r_a | r_b;
                            rsp_zero   <= ((r_a | r_b) == '0);
                        end
                    endcase
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_ready_sel) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : alu_share_arb
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Self-checking bench for alu_share_arb. A behavioural model
//               (plain arithmetic + round-robin rule) predicts the winner,
//               result, zero flag and latency of each operation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_arb;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;

    int total = 0;
    int bad   = 0;
    bit m_last = 1'b1;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    function automatic logic [W-1:0] model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic bit model_pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return !last;
        return v0 ? 1'b0 : 1'b1;
    endfunction

    // Runs one operation: present requests, observe grant, wait for the
    // response (bounded), optionally stall it, then retire it.
    task automatic xact(input bit v0, input bit v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                        input int hold,
                        output logic [1:0] got_ready, output logic [1:0] got_valid,
                        output logic [W-1:0] res, output logic z, output int lat,
                        output bit busy_ready, output bit unstable, output logic [1:0] post_valid);
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req0_op = op0;
        req1_a = a1; req1_b = b1; req1_op = op1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        busy_ready = 1'b0; unstable = 1'b0;
        #1;
        got_ready = {req1_ready, req0_ready};
        @(posedge clk); #1;
        // operands change after the accept edge; result must not follow them
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        lat = 1;
        while (!(rsp0_valid || rsp1_valid) && lat < 8) begin
            if (req0_ready || req1_ready) busy_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (req0_ready || req1_ready) busy_ready = 1'b1;
        got_valid = {rsp1_valid, rsp0_valid};
        res = rsp_result;
        z   = rsp_zero;
        for (int i = 0; i < hold; i++) begin
            // the non-owner's ready is raised to show it has no effect
            rsp0_ready = !rsp0_valid;
            rsp1_ready = !rsp1_valid;
            @(posedge clk); #1;
            if ({rsp1_valid, rsp0_valid} !== got_valid || rsp_result !== res ||
                rsp_zero !== z || req0_ready || req1_ready)
                unstable = 1'b1;
        end
        rsp0_ready = rsp0_valid; rsp1_ready = rsp1_valid;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        post_valid = {rsp1_valid, rsp0_valid};
    endtask

    logic [1:0]   g_rdy, g_vld, g_post;
    logic [W-1:0] g_res;
    logic         g_z;
    int           g_lat;
    bit           g_busy, g_unst;

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000) begin
            bad++; $display("FAIL reset_hs: got %b want 0000", {req1_ready, req0_ready, rsp1_valid, rsp0_valid});
        end
        total++;
        if (rsp_result !== '0 || rsp_zero !== 1'b1) begin
            bad++; $display("FAIL reset_rsp: got result=%h zero=%b want 0/1", rsp_result, rsp_zero);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        m_last = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        xact(1, 0, 32'd5, 32'd7, 3'b000, '0, '0, 3'b000, 0, g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
        m_last = model_pick(1, 0, m_last);
        total++;
        if (g_rdy !== 2'b01) begin bad++; $display("FAIL add_ready: got %b want 01", g_rdy); end
        total++;
        if (g_vld !== 2'b01 || g_lat !== 2) begin
            bad++; $display("FAIL add_rspvalid: got valid=%b lat=%0d want 01 lat=2", g_vld, g_lat);
        end
        total++;
        if (g_res !== 32'd12 || g_z !== 1'b0) begin
            bad++; $display("FAIL add_result: got %h z=%b want 0000000c z=0", g_res, g_z);
        end
        total++;
        if (g_post !== 2'b00 || g_busy) begin
            bad++; $display("FAIL add_retire: got post=%b busy_ready=%b want 00/0", g_post, g_busy);
        end
    endtask

    task automatic test_sub_zero();
        xact(0, 1, '0, '0, 3'b000, 32'd9, 32'd9, 3'b001, 0, g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
        m_last = model_pick(0, 1, m_last);
        total++;
        if (g_rdy !== 2'b10 || g_vld !== 2'b10) begin
            bad++; $display("FAIL sub_hs: got ready=%b valid=%b want 10/10", g_rdy, g_vld);
        end
        total++;
        if (g_res !== '0 || g_z !== 1'b1) begin
            bad++; $display("FAIL sub_zero: got %h z=%b want 0 z=1", g_res, g_z);
        end
    endtask

    task automatic test_wrap();
        xact(0, 1, '0, '0, 3'b000, 32'd0, 32'd1, 3'b001, 0, g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
        m_last = model_pick(0, 1, m_last);
        total++;
        if (g_res !== 32'hFFFF_FFFF || g_z !== 1'b0) begin
            bad++; $display("FAIL wrap_sub: got %h z=%b want ffffffff z=0", g_res, g_z);
        end
        xact(1, 0, 32'hFFFF_FFFF, 32'd1, 3'b000, '0, '0, 3'b000, 0, g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
        m_last = model_pick(1, 0, m_last);
        total++;
        if (g_res !== '0 || g_z !== 1'b1 || g_vld !== 2'b01) begin
            bad++; $display("FAIL wrap_add: got %h z=%b valid=%b want 0 z=1 01", g_res, g_z, g_vld);
        end
    endtask

    task automatic test_contention();
        bit w, prev;
        logic [W-1:0] exp;
        prev = m_last;
        for (int k = 0; k < 4; k++) begin
            xact(1, 1, 32'hF0F0, 32'h0FF0, 3'b010, 32'hF0F0, 32'h0FF0, 3'b111, 0,
                 g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
            w = model_pick(1, 1, m_last);
            m_last = w;
            exp = w ? 32'h0000_FFF0 : 32'h0000_00F0;
            total++;
            if (g_rdy !== (w ? 2'b10 : 2'b01) || w == prev) begin
                bad++; $display("FAIL contention_grant[%0d]: got %b want one-hot id %0d", k, g_rdy, w);
            end
            total++;
            if (g_res !== exp || g_vld !== (w ? 2'b10 : 2'b01) || g_busy) begin
                bad++; $display("FAIL contention_rsp[%0d]: got %h valid=%b busy=%b want %h", k, g_res, g_vld, g_busy, exp);
            end
            prev = w;
        end
    endtask

    task automatic test_backpressure();
        xact(1, 0, 32'd100, 32'd23, 3'b001, '0, '0, 3'b000, 5, g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
        m_last = model_pick(1, 0, m_last);
        total++;
        if (g_unst || g_res !== 32'd77 || g_vld !== 2'b01) begin
            bad++; $display("FAIL backpressure_hold: got unstable=%b result=%h valid=%b want 0/4d/01", g_unst, g_res, g_vld);
        end
        total++;
        if (g_post !== 2'b00) begin bad++; $display("FAIL backpressure_release: got %b want 00", g_post); end
        // IDLE right after release: a new request is readied immediately
        req1_valid = 1'b1; #1;
        total++;
        if (req1_ready !== 1'b1) begin bad++; $display("FAIL backpressure_idle: got ready=%b want 1", req1_ready); end
        req1_valid = 1'b0; #1;
    endtask

    task automatic test_reset_midflight();
        bit seen;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd1; req1_a = 32'd2; req1_b = 32'd2;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        total++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000 || rsp_result !== '0 || rsp_zero !== 1'b1) begin
            bad++; $display("FAIL midreset_state: got hs=%b result=%h zero=%b want 0000/0/1",
                            {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, rsp_result, rsp_zero);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL midreset_noresp: got response=1 want 0"); end
        xact(1, 1, 32'd3, 32'd4, 3'b000, 32'd8, 32'd8, 3'b011, 0, g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
        m_last = model_pick(1, 1, m_last);
        total++;
        if (g_rdy !== 2'b01 || g_res !== 32'd7) begin
            bad++; $display("FAIL midreset_tie: got ready=%b result=%h want 01/7", g_rdy, g_res);
        end
    endtask

    task automatic test_random();
        bit v0, v1, w;
        logic [W-1:0] a0, b0, a1, b1, exp;
        logic [2:0] op0, op1;
        int hold;
        for (int k = 0; k < 30; k++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = $urandom; a1 = $urandom; op0 = 3'($urandom); op1 = 3'($urandom);
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            hold = $urandom_range(0, 2);
            xact(v0, v1, a0, b0, op0, a1, b1, op1, hold, g_rdy, g_vld, g_res, g_z, g_lat, g_busy, g_unst, g_post);
            w = model_pick(v0, v1, m_last);
            m_last = w;
            exp = w ? model_alu(a1, b1, op1) : model_alu(a0, b0, op0);
            total++;
            if (g_rdy !== (w ? 2'b10 : 2'b01) || g_vld !== (w ? 2'b10 : 2'b01) || g_lat !== 2) begin
                bad++; $display("FAIL rand_hs[%0d]: got ready=%b valid=%b lat=%0d want id %0d lat=2", k, g_rdy, g_vld, g_lat, w);
            end
            total++;
            if (g_res !== exp || g_z !== (exp == '0) || g_unst || g_busy || g_post !== 2'b00) begin
                bad++; $display("FAIL rand_rsp[%0d]: got %h z=%b unst=%b busy=%b post=%b want %h", k, g_res, g_z, g_unst, g_busy, g_post, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_wrap();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_share_arb
`default_nettype wire
